// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for DIV/DIVU in EX: latches operands, runs one
// shift/subtract step per cycle, sign-corrects and returns {remainder, quotient}.
module div_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     dividend,
    input  logic [DATA_W-1:0]     divisor,
    input  logic                  annul,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready,
    output logic                  stall
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [DATA_W-1:0]     rem, rem_n;
    logic [DATA_W-1:0]     quo, quo_n;
    logic [DATA_W-1:0]     dvs, dvs_n;
    logic                  dvd_neg, dvd_neg_n;
    logic                  quo_neg, quo_neg_n;
    logic                  sgn, sgn_n;
    logic                  ready_n;
    logic [2*DATA_W-1:0]   result_n;

    // One restoring step: shifted partial remainder is DATA_W+1 bits wide
    logic [DATA_W:0]       rem_sh;
    logic                  fits;
    logic [DATA_W-1:0]     rem_step, quo_step, quo_fix, rem_fix;

    assign rem_sh   = {rem, quo[DATA_W-1]};
    assign fits     = (rem_sh >= {1'b0, dvs});
    assign rem_step = fits ? (rem_sh[DATA_W-1:0] - dvs) : rem_sh[DATA_W-1:0];
    assign quo_step = {quo[DATA_W-2:0], fits};
    assign quo_fix  = (quo_neg && sgn) ? -quo_step : quo_step;
    assign rem_fix  = (dvd_neg && sgn) ? -rem_step : rem_step;

    assign stall = start & ~ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FREE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            dvd_neg <= 1'b0;
            quo_neg <= 1'b0;
            sgn     <= 1'b0;
            ready   <= 1'b0;
            result  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rem     <= rem_n;
            quo     <= quo_n;
            dvs     <= dvs_n;
            dvd_neg <= dvd_neg_n;
            quo_neg <= quo_neg_n;
            sgn     <= sgn_n;
            ready   <= ready_n;
            result  <= result_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rem_n     = rem;
        quo_n     = quo;
        dvs_n     = dvs;
        dvd_neg_n = dvd_neg;
        quo_neg_n = quo_neg;
        sgn_n     = sgn;
        ready_n   = ready;
        result_n  = result;

        unique case (state)
            FREE: begin
                if (start && !annul) begin
                    if (divisor == '0) begin
                        state_n = BYZERO;
                    end else begin
                        state_n   = ON;
                        dvs_n     = (signed_div && divisor[DATA_W-1]) ? -divisor : divisor;
                        quo_n     = (signed_div && dividend[DATA_W-1]) ? -dividend : dividend;
                        rem_n     = '0;
                        cnt_n     = '0;
                        dvd_neg_n = dividend[DATA_W-1];
                        quo_neg_n = dividend[DATA_W-1] ^ divisor[DATA_W-1];
                        sgn_n     = signed_div;
                    end
                end
            end
            BYZERO: begin
                if (annul) begin
                    state_n = FREE;
                end else begin
                    state_n  = END;
                    result_n = '0;
                end
            end
            ON: begin
                if (annul) begin
                    state_n = FREE;
                end else begin
                    rem_n = rem_step;
                    quo_n = quo_step;
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state_n  = END;
                        result_n = {rem_fix, quo_fix};
                    end
                end
            end
            END: begin
                // Hold ready while EX keeps start high; release on its fall
                if (start) begin
                    ready_n = 1'b1;
                end else begin
                    state_n = FREE;
                    ready_n = 1'b0;
                end
            end
            default: state_n = FREE;
        endcase
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus random divides
// compared against a plain-arithmetic reference.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] last = '0;

    always #5 clk = ~clk;

    div_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .dividend(dividend), .divisor(divisor), .annul(annul),
        .result(result), .ready(ready), .stall(stall)
    );

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full handshake: raise start, wait for ready, check latency/result/stall, release
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit scramble, input bit annul_end);
        logic [63:0] exp;
        int          n;
        bit          stall_ok;
        bit          held;
        exp = ref_div(s, a, b);
        signed_div = s;
        dividend = a;
        divisor = b;
        start = 1'b1;
        #1;
        n = 0;
        stall_ok = 1'b1;
        while (ready !== 1'b1 && n < 100) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            step();
            n++;
            if (scramble) begin
                dividend = $urandom;
                divisor = $urandom;
            end
        end
        check("latency", 64'(n - 1), (b == 32'd0) ? 64'd2 : 64'd33);
        check("result", result, exp);
        check("busy_stall", 64'(stall_ok), 64'd1);
        check("stall_at_ready", 64'(stall), 64'd0);
        held = 1'b1;
        if (annul_end) annul = 1'b1;
        repeat (hold) begin
            step();
            if (ready !== 1'b1 || result !== exp) held = 1'b0;
        end
        annul = 1'b0;
        if (hold > 0) check("ready_held", 64'(held), 64'd1);
        start = 1'b0;
        step();
        check("ready_drop", 64'(ready), 64'd0);
        check("result_kept", result, exp);
        last = exp;
    endtask

    initial begin
        bit          quiet;
        logic [31:0] ra, rb;
        logic        rs;

        repeat (2) step();
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        rst = 1'b0;
        step();

        do_div(1'b0, 32'd100, 32'd7, 0, 1'b0, 1'b0);
        check("divu_100_7", last, {32'h2, 32'hE});
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
        check("div_m7_2", last, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, 1'b0);
        check("div_7_m2", last, {32'h1, 32'hFFFF_FFFD});
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        check("div_min_m1", last, {32'h0, 32'h8000_0000});
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        check("divu_min_max", last, {32'h8000_0000, 32'h0});
        do_div(1'b1, 32'h8000_0000, 32'd1, 0, 1'b0, 1'b0);
        do_div(1'b1, 32'd12345, 32'd0, 0, 1'b0, 1'b0);
        do_div(1'b0, 32'd12345678, 32'd97, 0, 1'b1, 1'b0);
        do_div(1'b1, 32'hF000_0001, 32'd33, 5, 1'b0, 1'b1);

        // Annul ten cycles into ON: must abort and leave result untouched
        signed_div = 1'b0;
        dividend = 32'd1000;
        divisor = 32'd3;
        start = 1'b1;
        repeat (11) step();
        annul = 1'b1;
        start = 1'b0;
        step();
        annul = 1'b0;
        check("annul_ready", 64'(ready), 64'd0);
        check("annul_result", result, last);
        quiet = 1'b1;
        repeat (40) begin
            step();
            if (ready !== 1'b0 || result !== last) quiet = 1'b0;
        end
        check("annul_quiet", 64'(quiet), 64'd1);
        do_div(1'b0, 32'd1000, 32'd3, 0, 1'b0, 1'b0);

        // Annul held in FREE suppresses accept
        start = 1'b1;
        annul = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            step();
            if (ready !== 1'b0) quiet = 1'b0;
        end
        check("annul_free", 64'(quiet), 64'd1);
        start = 1'b0;
        annul = 1'b0;
        step();

        // Reset mid-divide clears outputs asynchronously
        signed_div = 1'b1;
        dividend = 32'hDEAD_BEEF;
        divisor = 32'd5;
        start = 1'b1;
        repeat (15) step();
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_result", result, 64'd0);
        start = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("postrst_result", result, 64'd0);
        do_div(1'b0, 32'd81, 32'd9, 0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'h8000_0000;
                default: rb = 32'($urandom);
            endcase
            do_div(rs, ra, rb, 0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
